// File: rtl/det_pkg.sv
// Shared constants and state encoding for the 3x3 determinant feeder.
// The determinant core itself lives next to the feeder in the parent.
package det_pkg;

  localparam int DATA_W      = 32;
  localparam int N_ELEM      = 9;
  localparam int TIMEOUT_CYC = 64;

  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    KICK,
    WAIT,
    EMIT
  } feed_state_t;

endpackage

// File: rtl/det3x3_feeder.sv
// Stream front end for the 3x3 determinant core: gathers a row-major frame,
// starts the core, and returns the result or an in-band error.
module det3x3_feeder #(
  parameter int DATA_W      = det_pkg::DATA_W,
  parameter int N_ELEM      = det_pkg::N_ELEM,
  parameter int TIMEOUT_CYC = det_pkg::TIMEOUT_CYC
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_err,
  output logic                     core_start,
  output logic [N_ELEM*DATA_W-1:0] core_mat,
  input  logic                     core_busy,
  input  logic                     core_done,
  input  logic [DATA_W-1:0]        core_det
);

  import det_pkg::*;

  localparam int IDX_W = $clog2(N_ELEM);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  feed_state_t      state;
  logic [IDX_W-1:0] idx;
  logic [TMO_W-1:0] tmo;
  logic             s_fire;
  logic             m_fire;

  assign s_fire = s_valid && s_ready;
  assign m_fire = m_valid && m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOAD;
      idx        <= '0;
      tmo        <= '0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_err      <= 1'b0;
      core_start <= 1'b0;
      core_mat   <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_fire) begin
            for (int k = 0; k < N_ELEM; k++) begin
              if (idx == IDX_W'(k)) begin
                core_mat[k*DATA_W +: DATA_W] <= s_data;
              end
            end
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              if (s_last) begin
                // start goes out while KICK is current
                state      <= KICK;
                s_ready    <= 1'b0;
                core_start <= !core_busy;
              end else begin
                state <= DRAIN;
              end
            end else if (s_last) begin
              state   <= EMIT;
              s_ready <= 1'b0;
              m_valid <= 1'b1;
              m_err   <= 1'b1;
              m_data  <= '0;
            end
          end
        end
        DRAIN: begin
          if (s_fire && s_last) begin
            state   <= EMIT;
            s_ready <= 1'b0;
            m_valid <= 1'b1;
            m_err   <= 1'b1;
            m_data  <= '0;
          end
        end
        KICK: begin
          if (core_start) begin
            core_start <= 1'b0;
            tmo        <= '0;
            state      <= WAIT;
          end else if (!core_busy) begin
            core_start <= 1'b1;
          end
        end
        WAIT: begin
          tmo <= tmo + 1'b1;
          if (core_done) begin
            m_data  <= core_det;
            m_err   <= 1'b0;
            m_valid <= 1'b1;
            state   <= EMIT;
          end else if (tmo == TMO_LAST) begin
            m_data  <= '0;
            m_err   <= 1'b1;
            m_valid <= 1'b1;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (m_fire) begin
            m_valid <= 1'b0;
            idx     <= '0;
            s_ready <= 1'b1;
            state   <= LOAD;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det3x3_feeder.sv
// Bench for det3x3_feeder with a behavioural determinant core alongside.
// Table of frames plus hand-built backpressure, busy, timeout and reset cases.
module tb_det3x3_feeder;

  localparam int DW  = 32;
  localparam int NE  = 9;
  localparam int MW  = NE * DW;
  localparam int TMO = 16;
  localparam int NV  = 8;

  typedef struct {
    int              n;
    logic [11:0][31:0] e;
    logic [31:0]     exp;
    bit              err;
    bit              hang;
    int              nstart;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    bit          err;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_err;
  logic          core_start;
  logic [MW-1:0] core_mat;
  logic          core_busy;
  logic          core_done;
  logic [DW-1:0] core_det;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int starts = 0;
  int t_start = 0;
  int t_mv = 0;
  bit mv_q = 0;

  res_t        sb[$];
  logic [MW-1:0] exp_mat;
  vec_t        tbl[NV];

  // behavioural core
  int          lat = 2;
  bit          hang = 0;
  bit          force_busy = 0;
  logic        busy_m = 0;
  int          cnt = 0;
  logic        done_m = 0;
  logic [DW-1:0] det_m = '0;

  assign core_busy = busy_m | force_busy;
  assign core_done = done_m;
  assign core_det  = det_m;

  det3x3_feeder #(
    .DATA_W(DW),
    .N_ELEM(NE),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .s_last(s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_err(m_err),
    .core_start(core_start),
    .core_mat(core_mat),
    .core_busy(core_busy),
    .core_done(core_done),
    .core_det(core_det)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] det_of(input logic [MW-1:0] m);
    logic signed [31:0] a, b, c, d, e, f, g, h, i;
    a = m[0*32 +: 32]; b = m[1*32 +: 32]; c = m[2*32 +: 32];
    d = m[3*32 +: 32]; e = m[4*32 +: 32]; f = m[5*32 +: 32];
    g = m[6*32 +: 32]; h = m[7*32 +: 32]; i = m[8*32 +: 32];
    return a * (e * i - f * h) - b * (d * i - f * g) + c * (d * h - e * g);
  endfunction

  always @(posedge clk) begin
    done_m <= 1'b0;
    if (core_start && !hang) begin
      busy_m <= 1'b1;
      cnt    <= lat;
      det_m  <= det_of(core_mat);
    end else if (busy_m) begin
      if (cnt == 0) begin
        busy_m <= 1'b0;
        done_m <= 1'b1;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [MW-1:0] act,
                     input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: start pulses, m_valid rise time, scoreboard pop
  always @(negedge clk) begin
    if (reset_n) begin
      if (core_start) begin
        starts++;
        t_start = cyc;
        chk("core_mat", core_mat, exp_mat);
      end
      if (m_valid && !mv_q) t_mv = cyc;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", MW'(m_data), '1);
        end else begin
          res_t r;
          r = sb.pop_front();
          chk("m_data", MW'(m_data), MW'(r.data));
          chk("m_err", MW'(m_err), MW'(r.err));
        end
      end
    end
    mv_q = m_valid;
  end

  function automatic vec_t mk9(input logic [31:0] a, b, c, d, e, f, g, h, i,
                               input logic [31:0] x);
    vec_t v;
    v.n = 9;
    v.e = '0;
    v.e[0] = a; v.e[1] = b; v.e[2] = c;
    v.e[3] = d; v.e[4] = e; v.e[5] = f;
    v.e[6] = g; v.e[7] = h; v.e[8] = i;
    v.exp = x;
    v.err = 0;
    v.hang = 0;
    v.nstart = 1;
    return v;
  endfunction

  task automatic send_beat(input logic [31:0] d, input bit last);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout: beat %0h not accepted", d);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input bit push);
    res_t r;
    r.data = v.exp;
    r.err  = v.err;
    if (push) sb.push_back(r);
    for (int k = 0; k < NE; k++) exp_mat[k*32 +: 32] = v.e[k];
    for (int k = 0; k < v.n; k++) send_beat(v.e[k], k == v.n - 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = (sb.size() == 0) && !m_valid;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: %0d results pending", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    bit seen;
    vec_t v;

    tbl[0] = mk9(1, 0, 0, 0, 1, 0, 0, 0, 1, 32'd1);
    tbl[1] = mk9(1, 2, 3, 4, 5, 6, 7, 8, 10, 32'hFFFFFFFD);
    tbl[2] = mk9(-1, -2, -3, 4, 5, 6, 7, 8, 10, 32'd3);
    tbl[3] = mk9(1, 2, 3, 4, 5, 0, 0, 0, 0, 32'd0);
    tbl[3].n = 5; tbl[3].err = 1; tbl[3].nstart = 0;
    tbl[4] = mk9(1, 0, 0, 0, 1, 0, 0, 0, 1, 32'd1);
    tbl[5] = mk9(1, 2, 3, 4, 5, 6, 7, 8, 9, 32'd0);
    tbl[5].e[9] = 10; tbl[5].e[10] = 11; tbl[5].e[11] = 12;
    tbl[5].n = 12; tbl[5].err = 1; tbl[5].nstart = 0;
    tbl[6] = mk9(3, 1, 4, 1, 5, 9, 2, 6, 5, 32'hFFFFFFA6);
    tbl[7] = mk9(1, 0, 0, 0, 1, 0, 0, 0, 1, 32'd0);
    tbl[7].err = 1; tbl[7].hang = 1;

    reset_n = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    exp_mat = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", MW'(s_ready), '0);
    chk("rst_m_valid", MW'(m_valid), '0);
    chk("rst_core_start", MW'(core_start), '0);
    chk("rst_m_data", MW'(m_data), '0);
    chk("rst_m_err", MW'(m_err), '0);
    chk("rst_core_mat", core_mat, '0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_rst", MW'(s_ready), MW'(1));
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      s0   = starts;
      hang = tbl[i].hang;
      run_frame(tbl[i], 1'b1);
      wait_idle();
      chk("start_count", MW'(starts - s0), MW'(tbl[i].nstart));
      if (tbl[i].hang) chk("timeout_latency", MW'(t_mv - t_start), MW'(17));
    end
    hang = 0;

    // backpressure: result held until consumer is ready
    m_ready = 1'b0;
    run_frame(mk9(2, 0, 0, 0, 3, 0, 0, 0, 4, 32'd24), 1'b1);
    seen = 0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      seen = m_valid;
    end
    chk("bp_valid_seen", MW'(seen), MW'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_m_valid", MW'(m_valid), MW'(1));
      chk("bp_m_data", MW'(m_data), MW'(24));
      chk("bp_s_ready", MW'(s_ready), '0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_s_ready_after", MW'(s_ready), MW'(1));
    wait_idle();

    // core busy holds the start pulse back
    force_busy = 1'b1;
    s0 = starts;
    run_frame(tbl[0], 1'b1);
    repeat (6) @(negedge clk);
    chk("busy_no_start", MW'(starts - s0), '0);
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    wait_idle();
    chk("busy_one_start", MW'(starts - s0), MW'(1));

    // reset while waiting on a slow core
    lat = 30;
    s0 = starts;
    run_frame(tbl[0], 1'b0);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (starts != s0);
    end
    chk("slow_start_seen", MW'(seen), MW'(1));
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("wrst_s_ready", MW'(s_ready), '0);
    chk("wrst_m_valid", MW'(m_valid), '0);
    chk("wrst_core_start", MW'(core_start), '0);
    chk("wrst_m_data", MW'(m_data), '0);
    chk("wrst_m_err", MW'(m_err), '0);
    chk("wrst_core_mat", core_mat, '0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("wrst_s_ready_after", MW'(s_ready), MW'(1));
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_valid) seen = 1;
    end
    chk("late_done_ignored", MW'(seen), '0);
    @(posedge clk);
    #1;
    lat = 2;
    v = mk9(2, 1, 0, 1, 2, 1, 0, 1, 2, 32'd4);
    run_frame(v, 1'b1);
    wait_idle();

    chk("sb_empty", MW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
